// File: rtl/dcnt_pkg.sv
// Shared types and constants for the cascaded down-counter interval timer.
package dcnt_pkg;

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int unsigned NIB_MIN = 1;
    localparam int unsigned NIB_MAX = 8;

endpackage

// File: rtl/dcnt_nib_ld.sv
// One 4-bit down-counter stage with synchronous load and ripple borrow carry.
module dcnt_nib_ld (
    input  logic       CLK,
    input  logic       CDN,
    input  logic       LD,
    input  logic [3:0] D,
    input  logic       CAI,
    input  logic       EN,
    output logic [3:0] Q,
    output logic       CAO
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (LD) begin
            q_d = D;
        end else if (CAI && EN) begin
            q_d = q_q - 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q   = q_q;
    // Borrow into the next stage only while this stage is about to underflow.
    assign CAO = CAI & EN & (q_q == 4'd0);

endmodule

// File: rtl/dcnt_timer_ctl.sv
// Interval-timer controller: sequences a chain of 4-bit down stages, detects terminal
// count, reloads or stops by mode, and keeps a sticky acknowledged interrupt.
module dcnt_timer_ctl
    import dcnt_pkg::*;
#(
    parameter int unsigned NIB = 4,
    localparam int unsigned W  = 4 * NIB
) (
    input  logic         CLK,
    input  logic         CDN,
    input  logic [W-1:0] LOAD_VAL,
    input  logic         START,
    input  logic         STOP,
    input  logic         MODE,
    input  logic         CE,
    input  logic         IACK,
    output logic [W-1:0] CNT,
    output logic         BUSY,
    output logic         TC,
    output logic         IRQ,
    output logic         OVR
);

    if (NIB < NIB_MIN || NIB > NIB_MAX) begin : g_bad_nib
        $error("dcnt_timer_ctl: NIB out of range");
    end

    state_e       state_q, state_d;
    logic         tc_q, tc_d;
    logic         irq_q, irq_d;
    logic         ovr_q, ovr_d;
    logic [W-1:0] cnt;
    logic [NIB:0] carry;
    logic         running;
    logic         cnt_zero;
    logic         term;
    logic         chain_ld;
    logic         chain_en;

    assign running  = (state_q == RUN);
    assign cnt_zero = (cnt == '0);
    // STOP and START both pre-empt the tick arriving in the same cycle.
    assign term     = running & ~STOP & ~START & CE & cnt_zero;
    assign chain_ld = (START & ~STOP) | (term & (MODE == MODE_PERIODIC));
    // Gating on a non-zero count keeps the chain from wrapping to all-ones.
    assign chain_en = running & ~STOP & ~START & ~cnt_zero;
    assign carry[0] = CE;

    for (genvar g = 0; g < NIB; g++) begin : g_nib
        dcnt_nib_ld u_nib (
            .CLK (CLK),
            .CDN (CDN),
            .LD  (chain_ld),
            .D   (LOAD_VAL[4*g +: 4]),
            .CAI (carry[g]),
            .EN  (chain_en),
            .Q   (cnt[4*g +: 4]),
            .CAO (carry[g+1])
        );
    end

    always_comb begin
        state_d = state_q;
        if (STOP) begin
            state_d = IDLE;
        end else if (START) begin
            state_d = RUN;
        end else if (term && (MODE == MODE_ONESHOT)) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        tc_d  = term;
        irq_d = irq_q;
        ovr_d = ovr_q;
        if (term) begin
            irq_d = 1'b1;
            if (IACK) begin
                ovr_d = 1'b0;
            end else if (irq_q) begin
                ovr_d = 1'b1;
            end
        end else if (IACK) begin
            irq_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            state_q <= IDLE;
            tc_q    <= 1'b0;
            irq_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            irq_q   <= irq_d;
            ovr_q   <= ovr_d;
        end
    end

    // The final stage borrow can only rise if the chain were allowed to wrap.
    chain_no_wrap_a : assert property (@(posedge CLK) disable iff (!CDN) !carry[NIB]);

    assign CNT  = cnt;
    assign BUSY = running;
    assign TC   = tc_q;
    assign IRQ  = irq_q;
    assign OVR  = ovr_q;

endmodule

// File: tb/tb_dcnt_timer_ctl.sv
// Scoreboard bench for dcnt_timer_ctl: a behavioural model pushes expected outputs
// per driven cycle; each test task pops and compares after the edge.
module tb_dcnt_timer_ctl;

    logic        CLK = 1'b0;
    logic        CDN = 1'b0;
    logic [15:0] LOAD_VAL = '0;
    logic        START = 1'b0;
    logic        STOP = 1'b0;
    logic        MODE = 1'b0;
    logic        CE = 1'b0;
    logic        IACK = 1'b0;
    logic [15:0] CNT;
    logic        BUSY;
    logic        TC;
    logic        IRQ;
    logic        OVR;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [15:0] ld_v = '0;
    logic        mode_v = 1'b0;

    // Behavioural reference state
    logic        m_run = 1'b0;
    logic [15:0] m_cnt = '0;
    logic        m_tc = 1'b0;
    logic        m_irq = 1'b0;
    logic        m_ovr = 1'b0;

    logic [19:0] sb_q[$];

    dcnt_timer_ctl #(.NIB(4)) dut (
        .CLK      (CLK),
        .CDN      (CDN),
        .LOAD_VAL (LOAD_VAL),
        .START    (START),
        .STOP     (STOP),
        .MODE     (MODE),
        .CE       (CE),
        .IACK     (IACK),
        .CNT      (CNT),
        .BUSY     (BUSY),
        .TC       (TC),
        .IRQ      (IRQ),
        .OVR      (OVR)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset;
        m_run = 1'b0;
        m_cnt = '0;
        m_tc  = 1'b0;
        m_irq = 1'b0;
        m_ovr = 1'b0;
        sb_q.delete();
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs, then clock.
    task automatic step(input logic start, input logic stop, input logic ce, input logic iack);
        logic term;
        START = start;
        STOP = stop;
        CE = ce;
        IACK = iack;
        LOAD_VAL = ld_v;
        MODE = mode_v;
        term = 1'b0;
        if (stop) begin
            m_run = 1'b0;
        end else if (start) begin
            m_run = 1'b1;
            m_cnt = ld_v;
        end else if (m_run && ce) begin
            if (m_cnt == 16'd0) begin
                term = 1'b1;
                if (mode_v) m_cnt = ld_v;
                else m_run = 1'b0;
            end else begin
                m_cnt = m_cnt - 16'd1;
            end
        end
        if (term) begin
            if (iack) m_ovr = 1'b0;
            else if (m_irq) m_ovr = 1'b1;
            m_irq = 1'b1;
        end else if (iack) begin
            m_irq = 1'b0;
            m_ovr = 1'b0;
        end
        m_tc = term;
        sb_q.push_back({m_cnt, m_run, m_tc, m_irq, m_ovr});
        @(posedge CLK);
        #1;
        cyc++;
        START = 1'b0;
        STOP = 1'b0;
        IACK = 1'b0;
    endtask

    task automatic test_reset;
        logic [19:0] e;
        CDN = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({CNT, BUSY, TC, IRQ, OVR} !== 20'h0) begin
            failures++;
            $display("FAIL reset_initial got=%h exp=%h", {CNT, BUSY, TC, IRQ, OVR}, 20'h0);
        end
        @(negedge CLK);
        CDN = 1'b1;
        ld_v = 16'h0005;
        mode_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(i == 0, 1'b0, 1'b0, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if ({CNT, BUSY, TC, IRQ, OVR} !== e) begin
                failures++;
                $display("FAIL reset_load cyc=%0d got=%h exp=%h", cyc, {CNT, BUSY, TC, IRQ, OVR}, e);
            end
        end
        #3;
        CDN = 1'b0;
        #1;
        checks++;
        if ({CNT, BUSY, TC, IRQ, OVR} !== 20'h0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=%h", {CNT, BUSY, TC, IRQ, OVR}, 20'h0);
        end
        model_reset();
        @(negedge CLK);
        CDN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if ({CNT, BUSY, TC, IRQ, OVR} !== e || CNT !== 16'h0000) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, {CNT, BUSY, TC, IRQ, OVR}, e);
            end
        end
    endtask

    task automatic test_oneshot;
        logic [19:0] e;
        logic [15:0] exp_cnt[5] = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd0};
        ld_v = 16'h0003;
        mode_v = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(i == 0, 1'b0, 1'b1, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if ({CNT, BUSY, TC, IRQ, OVR} !== e) begin
                failures++;
                $display("FAIL oneshot cyc=%0d got=%h exp=%h", cyc, {CNT, BUSY, TC, IRQ, OVR}, e);
            end
            if (i < 5) begin
                checks++;
                if (CNT !== exp_cnt[i] || TC !== (i == 4)) begin
                    failures++;
                    $display("FAIL oneshot_seq i=%0d got cnt=%h tc=%b exp cnt=%h tc=%b",
                             i, CNT, TC, exp_cnt[i], (i == 4));
                end
            end
            if (i == 4) begin
                checks++;
                if (BUSY !== 1'b0 || IRQ !== 1'b1) begin
                    failures++;
                    $display("FAIL oneshot_end got busy=%b irq=%b exp busy=0 irq=1", BUSY, IRQ);
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        e = sb_q.pop_front();
        checks++;
        if ({CNT, BUSY, TC, IRQ, OVR} !== e) begin
            failures++;
            $display("FAIL oneshot_ack got=%h exp=%h", {CNT, BUSY, TC, IRQ, OVR}, e);
        end
    endtask

    task automatic test_periodic_cascade;
        logic [19:0] e;
        int tc_at[$];
        ld_v = 16'h0100;
        mode_v = 1'b1;
        for (int i = 0; i <= 600; i++) begin
            step(i == 0, 1'b0, 1'b1, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if ({CNT, BUSY, TC, IRQ, OVR} !== e) begin
                failures++;
                $display("FAIL periodic i=%0d got=%h exp=%h", i, {CNT, BUSY, TC, IRQ, OVR}, e);
            end
            if (TC === 1'b1) tc_at.push_back(i);
            if (i == 1) begin
                checks++;
                if (CNT !== 16'h00FF) begin
                    failures++;
                    $display("FAIL periodic_borrow got=%h exp=%h", CNT, 16'h00FF);
                end
            end
        end
        checks++;
        if (tc_at.size() != 2 || tc_at[0] != 257 || tc_at[1] != 514) begin
            failures++;
            $display("FAIL periodic_tc_spacing got count=%0d exp count=2 at 257,514", tc_at.size());
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        e = sb_q.pop_front();
        checks++;
        if ({CNT, BUSY, TC, IRQ, OVR} !== e) begin
            failures++;
            $display("FAIL periodic_stop got=%h exp=%h", {CNT, BUSY, TC, IRQ, OVR}, e);
        end
    endtask

    task automatic test_ce_gating;
        logic [19:0] e;
        int tc_at[$];
        ld_v = 16'h0002;
        mode_v = 1'b1;
        for (int i = 0; i <= 27; i++) begin
            step(i == 0, 1'b0, (i != 0) && (i % 3 == 0), 1'b0);
            e = sb_q.pop_front();
            checks++;
            if ({CNT, BUSY, TC, IRQ, OVR} !== e) begin
                failures++;
                $display("FAIL ce_gating i=%0d got=%h exp=%h", i, {CNT, BUSY, TC, IRQ, OVR}, e);
            end
            if (TC === 1'b1) tc_at.push_back(i);
        end
        checks++;
        if (tc_at.size() != 3 || tc_at[0] != 9 || tc_at[1] != 18 || tc_at[2] != 27) begin
            failures++;
            $display("FAIL ce_gating_period got count=%0d exp count=3 every 9", tc_at.size());
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        e = sb_q.pop_front();
        checks++;
        if ({CNT, BUSY, TC, IRQ, OVR} !== e) begin
            failures++;
            $display("FAIL ce_gating_stop got=%h exp=%h", {CNT, BUSY, TC, IRQ, OVR}, e);
        end
    endtask

    task automatic test_priority;
        logic [19:0] e;
        logic [15:0] lds[9] = '{16'h0040, 16'h0040, 16'h0055, 16'h0001, 16'h0001, 16'h0001,
                                16'h0009, 16'h0009, 16'h0009};
        logic [3:0] stim[9] = '{4'b1010, 4'b0010, 4'b1110, 4'b1010, 4'b0010, 4'b0110,
                                4'b1010, 4'b0010, 4'b0010};
        mode_v = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) begin
                ld_v = lds[i];
                step(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
            end else begin
                ld_v = 16'h0ABC;
                step(1'b1, 1'b0, 1'b1, 1'b0);
            end
            e = sb_q.pop_front();
            checks++;
            if ({CNT, BUSY, TC, IRQ, OVR} !== e) begin
                failures++;
                $display("FAIL priority i=%0d got=%h exp=%h", i, {CNT, BUSY, TC, IRQ, OVR}, e);
            end
            if (i == 2) begin
                checks++;
                if (BUSY !== 1'b0 || CNT !== 16'h003F) begin
                    failures++;
                    $display("FAIL stop_start got busy=%b cnt=%h exp busy=0 cnt=003f", BUSY, CNT);
                end
            end
            if (i == 5) begin
                checks++;
                if (TC !== 1'b0 || IRQ !== 1'b0 || BUSY !== 1'b0 || CNT !== 16'h0000) begin
                    failures++;
                    $display("FAIL stop_term got tc=%b irq=%b busy=%b cnt=%h exp 0 0 0 0000",
                             TC, IRQ, BUSY, CNT);
                end
            end
            if (i == 8) begin
                checks++;
                if (CNT !== 16'h0007) begin
                    failures++;
                    $display("FAIL restart_pre got=%h exp=%h", CNT, 16'h0007);
                end
            end
            if (i == 9) begin
                checks++;
                if (CNT !== 16'h0ABC || TC !== 1'b0 || BUSY !== 1'b1) begin
                    failures++;
                    $display("FAIL restart got cnt=%h tc=%b busy=%b exp 0abc 0 1", CNT, TC, BUSY);
                end
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        void'(sb_q.pop_front());
    endtask

    task automatic test_back_to_back;
        logic [19:0] e;
        logic [3:0] stim[5] = '{4'b1000, 4'b0010, 4'b0010, 4'b0101, 4'b0011};
        logic [1:0] exp_io[5] = '{2'b00, 2'b10, 2'b11, 2'b00, 2'b10};
        ld_v = 16'h0000;
        mode_v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            // Re-arm after the stop at index 3 so the last step is a terminal tick.
            if (i == 4) begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
                void'(sb_q.pop_front());
            end
            step(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
            e = sb_q.pop_front();
            checks++;
            if ({CNT, BUSY, TC, IRQ, OVR} !== e) begin
                failures++;
                $display("FAIL irq i=%0d got=%h exp=%h", i, {CNT, BUSY, TC, IRQ, OVR}, e);
            end
            checks++;
            if ({IRQ, OVR} !== exp_io[i]) begin
                failures++;
                $display("FAIL irq_ovr i=%0d got=%b exp=%b", i, {IRQ, OVR}, exp_io[i]);
            end
        end
        checks++;
        if (TC !== 1'b1) begin
            failures++;
            $display("FAIL tc_with_iack got=%b exp=1", TC);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic_cascade();
        test_ce_gating();
        test_priority();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
